// File: rtl/mem_write_packet_serializer_pkg.sv
// Shared packet-format definitions for the host-bound UART packet sources.
// Holds the packet type codes, the mem-write packet length and the serializer state encoding.
package mem_write_packet_serializer_pkg;

    typedef enum logic [7:0] {
        PKT_READ_REPLY = 8'h01,
        PKT_MEM_WRITE  = 8'h02,
        PKT_STATUS     = 8'h03
    } pkt_opcode_e;

    // Opcode + 2 address bytes + 36 tile bytes.
    localparam int PKT_MEM_WRITE_BYTES = 39;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SEND,
        GAP,
        WAIT,
        DONE
    } ser_state_e;

endpackage

// File: rtl/mem_write_packet_serializer.sv
// Pops one mem-write FIFO entry at a time and streams it MSB-first to uart_tx as
// OPCODE, addr[15:8], addr[7:0], tile bytes, after winning the shared UART from the arbiter.
module mem_write_packet_serializer
    import mem_write_packet_serializer_pkg::*;
#(
    parameter int          TILE_BITS = 288,
    parameter int          ADDR_BITS = 16,
    parameter logic [7:0]  OPCODE    = PKT_MEM_WRITE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_available,
    input  logic [ADDR_BITS-1:0] fifo_addr,
    input  logic [TILE_BITS-1:0] fifo_tile,
    output logic                 fifo_re,
    output logic                 tx_req,
    input  logic                 tx_grant,
    input  logic                 tx_busy,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [15:0]          packets_sent
);

    localparam int SHIFT_BITS = TILE_BITS + ADDR_BITS + 8;
    localparam int PKT_BYTES  = SHIFT_BITS / 8;
    localparam int CNT_W      = $clog2(PKT_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_BYTES - 1);

    ser_state_e             state;
    ser_state_e             state_next;
    logic [SHIFT_BITS-1:0]  shift_reg;
    logic [CNT_W-1:0]       byte_cnt;
    logic                   load;
    logic                   advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            byte_cnt     <= '0;
            packets_sent <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                shift_reg <= {OPCODE, fifo_addr, fifo_tile};
                byte_cnt  <= '0;
            end else if (advance) begin
                shift_reg <= {shift_reg[SHIFT_BITS-9:0], 8'h00};
                byte_cnt  <= byte_cnt + 1'b1;
            end
            if (state == DONE) begin
                packets_sent <= packets_sent + 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        fifo_re    = 1'b0;
        tx_req     = 1'b0;
        tx_en      = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                // No pop while reset is held, otherwise an entry would vanish unsent.
                if (fifo_available && !reset) begin
                    fifo_re    = 1'b1;
                    load       = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                tx_req = 1'b1;
                if (tx_grant) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                tx_req = 1'b1;
                if (!tx_busy) begin
                    tx_en      = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                // uart_tx needs a cycle to raise busy after accepting a byte.
                tx_req     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                tx_req = 1'b1;
                if (!tx_busy) begin
                    if (byte_cnt == LAST_BYTE) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = SEND;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_data = shift_reg[SHIFT_BITS-1 -: 8];
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_write_packet_serializer.sv
// Directed bench for mem_write_packet_serializer with a FWFT FIFO model, a uart_tx busy model
// and a byte scoreboard fed when entries are pushed and drained on every tx_en strobe.
module tb_mem_write_packet_serializer;

    logic         clk;
    logic         reset;
    logic         fifo_available;
    logic [15:0]  fifo_addr;
    logic [287:0] fifo_tile;
    logic         fifo_re;
    logic         tx_req;
    logic         tx_grant;
    logic         tx_busy;
    logic         tx_en;
    logic [7:0]   tx_data;
    logic         busy;
    logic [15:0]  packets_sent;

    mem_write_packet_serializer dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_available (fifo_available),
        .fifo_addr      (fifo_addr),
        .fifo_tile      (fifo_tile),
        .fifo_re        (fifo_re),
        .tx_req         (tx_req),
        .tx_grant       (tx_grant),
        .tx_busy        (tx_busy),
        .tx_en          (tx_en),
        .tx_data        (tx_data),
        .busy           (busy),
        .packets_sent   (packets_sent)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]   exp_q[$];
    logic [15:0]  fifo_addr_q[$];
    logic [287:0] fifo_tile_q[$];

    int   busy_len = 10;
    int   busy_cnt = 0;
    logic busy_force = 1'b0;
    logic pop_pending = 1'b0;
    logic en_pending = 1'b0;
    int   en_count = 0;
    int   fifo_re_count = 0;
    int   low_run = 0;
    logic req_seen = 1'b0;
    logic req_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_available = (fifo_addr_q.size() != 0);
        fifo_addr      = fifo_available ? fifo_addr_q[0] : 16'h0;
        fifo_tile      = fifo_available ? fifo_tile_q[0] : 288'h0;
        tx_busy        = busy_force || (busy_cnt != 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [15:0] addr, input logic [287:0] tile);
        logic [311:0] pkt;
        pkt = {8'h02, addr, tile};
        fifo_addr_q.push_back(addr);
        fifo_tile_q.push_back(tile);
        for (int i = 38; i >= 0; i--) begin
            exp_q.push_back(pkt[i*8 +: 8]);
        end
        refresh();
    endtask

    function automatic logic [287:0] rand_tile();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) begin
            t[i*32 +: 32] = $urandom;
        end
        return t;
    endfunction

    task automatic wait_packets(input logic [15:0] target, input string tag);
        for (int i = 0; i < 3000 && packets_sent !== target; i++) step();
        check(tag, packets_sent, target);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 50 && tx_req !== 1'b1; i++) step();
        check(tag, tx_req, 1'b1);
    endtask

    task automatic wait_en(input int target, input string tag);
        for (int i = 0; i < 3000 && en_count < target; i++) step();
        check(tag, en_count, target);
    endtask

    // FIFO pop and uart_tx busy model, applied just after each active edge
    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_addr_q.size() != 0) begin
            void'(fifo_addr_q.pop_front());
            void'(fifo_tile_q.pop_front());
        end
        if (pop_pending) fifo_re_count++;
        if (en_pending) busy_cnt = busy_len;
        else if (busy_cnt != 0) busy_cnt--;
        refresh();
    end

    // scoreboard and protocol monitor, sampled on the falling edge
    always @(negedge clk) begin
        pop_pending = fifo_re;
        en_pending  = tx_en;
        if (!reset) begin
            if (fifo_re) begin
                check("pop_while_busy", busy, 1'b0);
                check("pop_with_req", tx_req, 1'b0);
            end
            if (tx_en) begin
                en_count++;
                if (exp_q.size() == 0) check("unexpected_byte", tx_data, 32'hFFFF_FFFF);
                else check("tx_byte", tx_data, exp_q.pop_front());
            end
            if (tx_req) begin
                if (!req_prev && req_seen) check("req_low_gap_ge2", low_run >= 2, 1'b1);
                low_run  = 0;
                req_seen = 1'b1;
            end else begin
                low_run++;
            end
            req_prev = tx_req;
        end
    end

    initial begin
        logic [287:0] tile;
        int base_en;
        int base_re;

        reset    = 1'b1;
        tx_grant = 1'b0;
        refresh();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fifo_re", fifo_re, 1'b0);
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_tx_en", tx_en, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_packets", packets_sent, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single packet, grant tied high
        tx_grant = 1'b1;
        tile = {36{8'hA5}};
        tile[7:0] = 8'h3C;
        push_entry(16'h1234, tile);
        wait_packets(16'd1, "t1_done");
        repeat (3) step();
        check("t1_packets", packets_sent, 16'd1);
        check("t1_bytes", en_count, 39);
        check("t1_pops", fifo_re_count, 1);
        check("t1_sb_empty", exp_q.size(), 0);
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_req", tx_req, 1'b0);

        // grant withheld while a second entry waits
        tx_grant = 1'b0;
        push_entry(16'hBEEF, rand_tile());
        push_entry(16'h0001, rand_tile());
        wait_req("t2_req_rise");
        base_re = fifo_re_count;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t2_no_en", tx_en, 1'b0);
            check("t2_req_held", tx_req, 1'b1);
            check("t2_no_pop", fifo_re_count, base_re);
        end
        tx_grant = 1'b1;
        step();
        check("t2_first_en", tx_en, 1'b1);
        wait_packets(16'd3, "t2_done");
        repeat (3) step();
        check("t2_pops", fifo_re_count, 3);
        check("t2_bytes", en_count, 117);
        check("t2_sb_empty", exp_q.size(), 0);

        // back-to-back entries with a short busy time
        busy_len = $urandom_range(2, 5);
        push_entry(16'hFFFF, rand_tile());
        push_entry(16'h8000, {36{8'h00}});
        wait_packets(16'd5, "t3_done");
        repeat (3) step();
        check("t3_pops", fifo_re_count, 5);
        check("t3_bytes", en_count, 195);
        check("t3_sb_empty", exp_q.size(), 0);

        // uart held busy while the serializer sits in SEND
        busy_len = 10;
        busy_force = 1'b1;
        refresh();
        push_entry(16'h5A5A, rand_tile());
        wait_req("t4_req_rise");
        repeat (2) step();
        base_en = en_count;
        for (int i = 0; i < 50; i++) begin
            step();
            check("t4_no_en", tx_en, 1'b0);
            check("t4_data_stable", tx_data, 8'h02);
        end
        check("t4_no_bytes", en_count, base_en);
        busy_force = 1'b0;
        refresh();
        #1;
        check("t4_en_on_fall", tx_en, 1'b1);
        wait_packets(16'd6, "t4_done");
        repeat (3) step();
        check("t4_sb_empty", exp_q.size(), 0);

        // reset in the middle of a packet
        base_en = en_count;
        push_entry(16'hC0DE, rand_tile());
        wait_en(base_en + 10, "t5_ten_bytes");
        reset = 1'b1;
        step();
        check("t5_fifo_re", fifo_re, 1'b0);
        check("t5_tx_req", tx_req, 1'b0);
        check("t5_tx_en", tx_en, 1'b0);
        check("t5_tx_data", tx_data, 8'h00);
        check("t5_busy", busy, 1'b0);
        check("t5_packets", packets_sent, 16'h0);
        reset = 1'b0;
        exp_q.delete();
        base_re = fifo_re_count;
        repeat (3) step();
        check("t5_no_repop", fifo_re_count, base_re);
        push_entry(16'h0042, rand_tile());
        wait_packets(16'd1, "t5_done");
        repeat (3) step();
        check("t5_sb_empty", exp_q.size(), 0);

        // packet counter wrap
        force dut.packets_sent = 16'hFFFF;
        #1;
        release dut.packets_sent;
        #1;
        check("t6_preload", packets_sent, 16'hFFFF);
        busy_len = 2;
        push_entry(16'h7777, rand_tile());
        wait_req("t6_req_rise");
        wait_packets(16'h0000, "t6_wrap");
        check("t6_known", $isunknown(packets_sent), 1'b0);
        repeat (3) step();
        check("t6_sb_empty", exp_q.size(), 0);
        check("t6_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
